// File: rtl/pixel_stream_source.sv
// pixel_stream_source
//   Producer side of the pixel FIFO feeding the VGA pixel generator. Emits one
//   active frame of raster-ordered RGB test-pattern pixels as 32-bit words
//   over a valid/ready handshake, tagged with start-of-frame / end-of-line.
//
// Ports
//   VGA_CLK      pixel clock, all state on rising edge
//   a_reset      asynchronous active-low reset
//   enable       start / continue frame generation
//   frame_start  one-cycle pulse at start of vertical blank
//   KEY[3:0]     active-low keys, KEY[1:0] select pattern (latched per frame)
//   ready        FIFO can accept a word
//   valid        fifo_data holds a valid pixel word
//   fifo_data    {6'b0, EOL, SOF, R[7:0], G[7:0], B[7:0]}
//   frame_count  completed frames, wraps
//   busy         high while running or waiting for frame_start
module pixel_stream_source #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned BAR_W      = H_ACTIVE / 8,
   parameter int unsigned CHECK_LOG2 = 5,
   parameter logic [23:0] SOLID_RGB  = 24'h0000FF,
   parameter bit          SYNC_LOCK  = 1'b1
) (
   input  logic        VGA_CLK,
   input  logic        a_reset,
   input  logic        enable,
   input  logic        frame_start,
   input  logic [3:0]  KEY,
   input  logic        ready,
   output logic        valid,
   output logic [31:0] fifo_data,
   output logic [7:0]  frame_count,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      WAIT_SYNC = 2'd2
   } state_t;

   state_t      state_q;
   logic [11:0] x_q, y_q;
   logic [11:0] x_d, y_d;
   logic [1:0]  mode_q;
   logic        valid_q;
   logic [31:0] data_q;
   logic [7:0]  frame_cnt_q;
   logic        busy_q;
   logic        xfer;
   logic        last_pix;
   logic [1:0]  key_mode;
   logic        unused_key;

   assign unused_key = ^KEY[3:2];
   assign key_mode   = ~KEY[1:0];
   assign xfer       = valid_q && ready;
   assign last_pix   = (x_q == 12'(H_ACTIVE - 1)) && (y_q == 12'(V_ACTIVE - 1));

   // Raster position of the pixel that follows the one currently presented.
   always_comb begin
      x_d = x_q + 12'd1;
      y_d = y_q;
      if (x_q == 12'(H_ACTIVE - 1)) begin
         x_d = '0;
         y_d = y_q + 12'd1;
      end
   end

   function automatic logic [31:0] pixel(input logic [11:0] px,
                                         input logic [11:0] py,
                                         input logic [1:0]  m);
      logic [23:0] rgb;
      logic [2:0]  idx;
      // Bar index as a count of crossed bar boundaries: equals x/BAR_W
      // clamped to 7 without needing a divider.
      idx = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if ({20'd0, px} >= k * BAR_W) idx = idx + 3'd1;
      end
      rgb = '0;
      case (m)
         2'd0: begin
            case (idx)
               3'd0:    rgb = 24'hFFFFFF;
               3'd1:    rgb = 24'hFFFF00;
               3'd2:    rgb = 24'h00FFFF;
               3'd3:    rgb = 24'h00FF00;
               3'd4:    rgb = 24'hFF00FF;
               3'd5:    rgb = 24'hFF0000;
               3'd6:    rgb = 24'h0000FF;
               default: rgb = 24'h000000;
            endcase
         end
         2'd1:    rgb = (px[CHECK_LOG2] ^ py[CHECK_LOG2]) ? '0 : '1;
         2'd2:    rgb = {px[9:2], py[8:1], 8'h00};
         default: rgb = SOLID_RGB;
      endcase
      return {6'd0, (px == 12'(H_ACTIVE - 1)), (px == 12'd0 && py == 12'd0), rgb};
   endfunction

   always_ff @(posedge VGA_CLK or negedge a_reset) begin
      if (!a_reset) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         mode_q      <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         frame_cnt_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               if (enable) begin
                  mode_q  <= key_mode;
                  x_q     <= '0;
                  y_q     <= '0;
                  data_q  <= pixel(12'd0, 12'd0, key_mode);
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (xfer) begin
                  if (last_pix) begin
                     frame_cnt_q <= frame_cnt_q + 8'd1;
                     if (!enable) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                     end else if (SYNC_LOCK) begin
                        valid_q <= 1'b0;
                        state_q <= WAIT_SYNC;
                     end else begin
                        mode_q <= key_mode;
                        x_q    <= '0;
                        y_q    <= '0;
                        data_q <= pixel(12'd0, 12'd0, key_mode);
                     end
                  end else begin
                     // Next word registered on the transfer edge: no bubbles.
                     x_q    <= x_d;
                     y_q    <= y_d;
                     data_q <= pixel(x_d, y_d, mode_q);
                  end
               end
            end
            WAIT_SYNC: begin
               if (!enable) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (frame_start) begin
                  mode_q  <= key_mode;
                  x_q     <= '0;
                  y_q     <= '0;
                  data_q  <= pixel(12'd0, 12'd0, key_mode);
                  valid_q <= 1'b1;
                  state_q <= RUN;
               end
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign valid       = valid_q;
   assign fifo_data   = data_q;
   assign frame_count = frame_cnt_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
module tb_pixel_stream_source;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Full-size instance (640x480) for pattern values at real coordinates.
   logic        b_rst_n, b_en, b_fs, b_rdy;
   logic [3:0]  b_key;
   logic        b_valid, b_busy;
   logic [31:0] b_data;
   logic [7:0]  b_fc;

   // Reduced instance (16x8) so whole frames and frame boundaries are cheap.
   logic        s_rst_n, s_en, s_fs, s_rdy;
   logic [3:0]  s_key;
   logic        s_valid, s_busy;
   logic [31:0] s_data;
   logic [7:0]  s_fc;

   pixel_stream_source #(
      .H_ACTIVE(640), .V_ACTIVE(480), .BAR_W(80), .CHECK_LOG2(5),
      .SOLID_RGB(24'h0000FF), .SYNC_LOCK(1'b1)
   ) u_big (
      .VGA_CLK(clk), .a_reset(b_rst_n), .enable(b_en), .frame_start(b_fs),
      .KEY(b_key), .ready(b_rdy), .valid(b_valid), .fifo_data(b_data),
      .frame_count(b_fc), .busy(b_busy)
   );

   pixel_stream_source #(
      .H_ACTIVE(16), .V_ACTIVE(8), .BAR_W(2), .CHECK_LOG2(2),
      .SOLID_RGB(24'h0000FF), .SYNC_LOCK(1'b1)
   ) u_small (
      .VGA_CLK(clk), .a_reset(s_rst_n), .enable(s_en), .frame_start(s_fs),
      .KEY(s_key), .ready(s_rdy), .valid(s_valid), .fifo_data(s_data),
      .frame_count(s_fc), .busy(s_busy)
   );

   // Reference pixel word computed from coordinates.
   function automatic logic [31:0] model(input int unsigned x, input int unsigned y,
                                         input logic [1:0] m, input int unsigned h,
                                         input int unsigned barw, input int unsigned cl);
      logic [23:0] rgb;
      int unsigned idx;
      rgb = 24'h0;
      case (m)
         2'd0: begin
            idx = x / barw;
            if (idx > 7) idx = 7;
            case (idx)
               0: rgb = 24'hFFFFFF;
               1: rgb = 24'hFFFF00;
               2: rgb = 24'h00FFFF;
               3: rgb = 24'h00FF00;
               4: rgb = 24'hFF00FF;
               5: rgb = 24'hFF0000;
               6: rgb = 24'h0000FF;
               default: rgb = 24'h000000;
            endcase
         end
         2'd1: rgb = ((((x >> cl) ^ (y >> cl)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
         2'd2: rgb = {8'((x >> 2) & 255), 8'((y >> 1) & 255), 8'h00};
         default: rgb = 24'h0000FF;
      endcase
      return {6'd0, (x == h - 1), (x == 0 && y == 0), rgb};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      b_rst_n = 1'b0; b_en = 1'b0; b_fs = 1'b0; b_rdy = 1'b1; b_key = 4'hF;
      s_rst_n = 1'b0; s_en = 1'b0; s_fs = 1'b0; s_rdy = 1'b1; s_key = 4'hF;
      tick(); tick();
      n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", b_valid); end
      n_cmp++; if (b_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", b_data); end
      n_cmp++; if (b_fc !== 8'h0) begin n_bad++; $display("FAIL reset_fc: got %0d want 0", b_fc); end
      n_cmp++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", b_busy); end
      n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL reset_s_valid: got %b want 0", s_valid); end
      b_rst_n = 1'b1;
      s_rst_n = 1'b1;
      tick();
      n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL idle_no_enable: got %b want 0", b_valid); end
   endtask

   // Enable pulse on the big instance, then stream words 0..last checking each
   // against the model and three hand-computed words. Optional 5-cycle stall.
   task automatic test_big_stream(input string name, input logic [3:0] key,
                                  input int unsigned last, input bit stall,
                                  input int unsigned i0, input logic [31:0] e0,
                                  input int unsigned i1, input logic [31:0] e1,
                                  input int unsigned i2, input logic [31:0] e2);
      int unsigned n;
      logic [31:0] held, exp;
      logic [1:0]  m;
      bit stalled;
      m = ~key[1:0];
      b_key = key; b_rdy = 1'b1; b_en = 1'b1;
      tick();
      b_en = 1'b0;
      n_cmp++; if (b_busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b want 1", name, b_busy); end
      n = 0;
      stalled = 1'b0;
      for (int cyc = 0; cyc < int'(last) + 100 && n <= last; cyc++) begin
         if (stall && !stalled && n == 100) begin
            stalled = 1'b1;
            b_rdy = 1'b0;
            held = b_data;
            for (int k = 0; k < 5; k++) begin
               tick();
               n_cmp++; if (b_valid !== 1'b1 || b_data !== held) begin
                  n_bad++; $display("FAIL %s_stall: valid %b data %h want 1 %h", name, b_valid, b_data, held);
               end
               b_key = 4'b1110; // key activity mid-frame must not matter
            end
            b_rdy = 1'b1;
         end
         if (b_valid !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_valid_drop: word %0d got valid %b want 1", name, n, b_valid);
            break;
         end
         exp = model(n % 640, n / 640, m, 640, 80, 5);
         n_cmp++; if (b_data !== exp) begin
            n_bad++; $display("FAIL %s_word%0d: got %h want %h", name, n, b_data, exp);
         end
         if (n == i0) begin n_cmp++; if (b_data !== e0) begin n_bad++; $display("FAIL %s_w%0d: got %h want %h", name, n, b_data, e0); end end
         if (n == i1) begin n_cmp++; if (b_data !== e1) begin n_bad++; $display("FAIL %s_w%0d: got %h want %h", name, n, b_data, e1); end end
         if (n == i2) begin n_cmp++; if (b_data !== e2) begin n_bad++; $display("FAIL %s_w%0d: got %h want %h", name, n, b_data, e2); end end
         n++;
         tick();
      end
      if (n <= last) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: reached %0d words want %0d", name, n, last + 1);
      end
   endtask

   task automatic test_bars_backpressure();
      test_big_stream("bars", 4'hF, 5000, 1'b1,
                      0, 32'h01FFFFFF, 80, 32'h00FFFF00, 639, 32'h02000000);
   endtask

   task automatic test_async_reset();
      #2;
      b_rst_n = 1'b0;
      #1;
      n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL async_valid: got %b want 0", b_valid); end
      n_cmp++; if (b_fc !== 8'h0) begin n_bad++; $display("FAIL async_fc: got %0d want 0", b_fc); end
      n_cmp++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL async_busy: got %b want 0", b_busy); end
      n_cmp++; if (b_data !== 32'h0) begin n_bad++; $display("FAIL async_data: got %h want 00000000", b_data); end
      tick();
      b_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_checker();
      test_big_stream("checker", 4'b1110, 20512, 1'b0,
                      0, 32'h01FFFFFF, 32, 32'h00000000, 20512, 32'h00FFFFFF);
      b_rst_n = 1'b0; tick(); b_rst_n = 1'b1; tick();
   endtask

   task automatic test_gradient();
      test_big_stream("gradient", 4'b1101, 1928, 1'b0,
                      0, 32'h01000000, 639, 32'h029F0000, 1928, 32'h00020100);
   endtask

   // Streams one whole 16x8 frame on the small instance; the first word must
   // already be presented. Optional mid-frame events at given word indices.
   task automatic run_small_frame(input string name, input logic [1:0] m,
                                  input int unsigned drop_at, input int unsigned key_at,
                                  input logic [3:0] new_key, input int unsigned fs_at,
                                  input logic [31:0] last_exp);
      logic [31:0] exp;
      int unsigned n;
      n = 0;
      for (int cyc = 0; cyc < 128; cyc++) begin
         if (s_valid !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_valid_drop: word %0d got valid %b want 1", name, n, s_valid);
            break;
         end
         if (n == drop_at) s_en = 1'b0;
         if (n == key_at) s_key = new_key;
         s_fs = (n == fs_at);
         exp = model(n % 16, n / 16, m, 16, 2, 2);
         n_cmp++; if (s_data !== exp) begin
            n_bad++; $display("FAIL %s_word%0d: got %h want %h", name, n, s_data, exp);
         end
         if (n == 127) begin
            n_cmp++; if (s_data !== last_exp) begin n_bad++; $display("FAIL %s_last: got %h want %h", name, s_data, last_exp); end
         end
         n++;
         tick();
         s_fs = 1'b0;
      end
      n_cmp++; if (s_valid !== 1'b0 || n != 128) begin
         n_bad++; $display("FAIL %s_end: valid %b words %0d want 0 128", name, s_valid, n);
      end
   endtask

   task automatic test_sync_lock();
      s_key = 4'hF; s_rdy = 1'b1; s_en = 1'b1;
      tick();
      n_cmp++; if (s_data !== 32'h01FFFFFF) begin n_bad++; $display("FAIL sync_first: got %h want 01FFFFFF", s_data); end
      run_small_frame("frame1", 2'd0, 999, 999, 4'hF, 999, 32'h02000000);
      n_cmp++; if (s_fc !== 8'd1) begin n_bad++; $display("FAIL frame1_fc: got %0d want 1", s_fc); end
      n_cmp++; if (s_busy !== 1'b1) begin n_bad++; $display("FAIL wait_busy: got %b want 1", s_busy); end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL wait_valid: got %b want 0", s_valid); end
      end
      s_fs = 1'b1; tick(); s_fs = 1'b0;
      n_cmp++; if (s_valid !== 1'b1 || s_data !== 32'h01FFFFFF) begin
         n_bad++; $display("FAIL sync_restart: valid %b data %h want 1 01FFFFFF", s_valid, s_data);
      end
      // frame_start mid-frame ignored; KEY change to gradient waits for next frame
      run_small_frame("frame2", 2'd0, 999, 30, 4'b1101, 20, 32'h02000000);
      n_cmp++; if (s_fc !== 8'd2) begin n_bad++; $display("FAIL frame2_fc: got %0d want 2", s_fc); end
      s_fs = 1'b1; tick(); s_fs = 1'b0;
      n_cmp++; if (s_data !== 32'h01000000) begin n_bad++; $display("FAIL grad_first: got %h want 01000000", s_data); end
   endtask

   task automatic test_drop_enable();
      run_small_frame("frame3", 2'd2, 10, 999, 4'hF, 999, 32'h02030300);
      n_cmp++; if (s_fc !== 8'd3) begin n_bad++; $display("FAIL frame3_fc: got %0d want 3", s_fc); end
      n_cmp++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b want 0", s_busy); end
      s_fs = 1'b1; tick(); s_fs = 1'b0; tick();
      n_cmp++; if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
         n_bad++; $display("FAIL idle_fs: valid %b busy %b want 0 0", s_valid, s_busy);
      end
   endtask

   task automatic test_solid();
      s_key = 4'b1100; s_en = 1'b1;
      tick();
      s_en = 1'b0;
      n_cmp++; if (s_data !== 32'h010000FF) begin n_bad++; $display("FAIL solid_first: got %h want 010000FF", s_data); end
      run_small_frame("frame4", 2'd3, 999, 999, 4'hF, 999, 32'h020000FF);
      n_cmp++; if (s_fc !== 8'd4 || s_busy !== 1'b0) begin
         n_bad++; $display("FAIL frame4_end: fc %0d busy %b want 4 0", s_fc, s_busy);
      end
   endtask

   initial begin
      test_reset();
      test_bars_backpressure();
      test_async_reset();
      test_checker();
      test_gradient();
      test_sync_lock();
      test_drop_enable();
      test_solid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
